branch_resolve_unit: RTL and testbench

// Consumes issued branches/jumps from the branch buffer, reads their operands from the physical register files,

---
 rtl/branch_resolve_unit.sv | 178 +++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Resolves branches/jumps: reads operands, computes direction/target, reports to ROB, recovers on mispredict.
// Latency: result two edges after acceptance (E1 read, E2 resolve); one branch per cycle while idle.
// Backpressure: in_ready drops during the flush cycle, the recovery stall, kill and reset.
module branch_resolve_unit #(
  parameter int PC_W        = 16,
  parameter int D_AW        = 5,
  parameter int S_AW        = 3,
  parameter int ROB_AW      = 4,
  parameter int RECOVER_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ROB_AW-1:0] in_rob_addr,
  input  logic              in_jump,
  input  logic              in_predict_taken,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [PC_W-1:0]   in_predict_target,
  input  logic [D_AW-1:0]   in_rt_addr,
  input  logic [D_AW-1:0]   in_rw_addr,
  input  logic [S_AW-1:0]   in_rs_addr,
  output logic [D_AW-1:0]   rt_rd_addr,
  input  logic [PC_W-1:0]   rt_rd_data,
  output logic [S_AW-1:0]   rs_rd_addr,
  input  logic              rs_rd_data,
  input  logic              kill,
  output logic              res_valid,
  output logic [ROB_AW-1:0] res_rob_addr,
  output logic              res_mispredict,
  output logic              wb_valid,
  output logic [D_AW-1:0]   wb_addr,
  output logic [PC_W-1:0]   wb_data,
  output logic              flush,
  output logic [ROB_AW-1:0] flush_rob_addr,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_pc
);

  typedef enum logic {IDLE, STALL} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;

  // E1: captured fields and register-file operands
  logic              e1_vld;
  logic [ROB_AW-1:0] e1_rob;
  logic              e1_jump, e1_pt, e1_flag;
  logic [PC_W-1:0]   e1_pc, e1_ptgt, e1_rt;
  logic [D_AW-1:0]   e1_rw;

  // E2: resolved outcome
  logic              e2_vld, e2_mis, e2_jump;
  logic [ROB_AW-1:0] e2_rob;
  logic [PC_W-1:0]   e2_actual, e2_link;
  logic [D_AW-1:0]   e2_rw;

  logic              accept, mis_fire, e1_taken, e1_mis;
  logic [PC_W-1:0]   e1_link, e1_actual;

  // Operands are read combinationally in the acceptance cycle.
  assign rt_rd_addr = in_rt_addr;
  assign rs_rd_addr = in_rs_addr;

  assign in_ready = ~rst & (state == IDLE) & ~flush & ~kill;
  assign accept   = in_valid & in_ready;

  // Resolution arithmetic on the E1 contents; link wraps modulo 2^PC_W.
  assign e1_link   = e1_pc + PC_W'(1);
  assign e1_taken  = e1_jump | e1_flag;
  assign e1_actual = e1_taken ? e1_rt : e1_link;
  assign e1_mis    = (e1_taken != e1_pt) | (e1_taken & (e1_rt != e1_ptgt));

  // kill suppresses everything E2 would report this cycle, including recovery.
  assign mis_fire       = e2_vld & e2_mis & ~kill & (state == IDLE);
  assign res_valid      = e2_vld & ~kill;
  assign res_rob_addr   = res_valid ? e2_rob : '0;
  assign res_mispredict = res_valid & e2_mis;
  assign wb_valid       = res_valid & e2_jump;
  assign wb_addr        = wb_valid ? e2_rw : '0;
  assign wb_data        = wb_valid ? e2_link : '0;
  assign flush          = mis_fire;
  assign flush_rob_addr = mis_fire ? e2_rob : '0;
  assign redirect_valid = mis_fire;
  assign redirect_pc    = mis_fire ? e2_actual : '0;

  // E1 stage: capture accepted entry; a flush or kill drops the younger entry held here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e1_vld  <= 1'b0;
      e1_rob  <= '0;
      e1_jump <= 1'b0;
      e1_pt   <= 1'b0;
      e1_flag <= 1'b0;
      e1_pc   <= '0;
      e1_ptgt <= '0;
      e1_rt   <= '0;
      e1_rw   <= '0;
    end else begin
      e1_vld <= accept & ~kill & ~flush;
      if (accept) begin
        e1_rob  <= in_rob_addr;
        e1_jump <= in_jump;
        e1_pt   <= in_predict_taken;
        e1_flag <= rs_rd_data;
        e1_pc   <= in_pc;
        e1_ptgt <= in_predict_target;
        e1_rt   <= rt_rd_data;
        e1_rw   <= in_rw_addr;
      end
    end
  end

  // E2 stage: register the resolved outcome for reporting next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e2_vld    <= 1'b0;
      e2_mis    <= 1'b0;
      e2_jump   <= 1'b0;
      e2_rob    <= '0;
      e2_actual <= '0;
      e2_link   <= '0;
      e2_rw     <= '0;
    end else begin
      e2_vld <= e1_vld & ~kill & ~flush;
      if (e1_vld) begin
        e2_mis    <= e1_mis;
        e2_jump   <= e1_jump;
        e2_rob    <= e1_rob;
        e2_actual <= e1_actual;
        e2_link   <= e1_link;
        e2_rw     <= e1_rw;
      end
    end
  end

  // Recovery state register and stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: a mispredict starts a fixed stall while the front end refills; kill aborts it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (kill) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (mis_fire) begin
            state_nxt = STALL;
            cnt_nxt   = 4'(RECOVER_CYC);
          end
        end
        STALL: begin
          cnt_nxt = cnt - 4'd1;
          if (cnt <= 4'd1) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
`timescale 1ns/1ps
module tb_branch_resolve_unit;
  localparam int PC_W = 16, D_AW = 5, S_AW = 3, ROB_AW = 4, RC = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid = 1'b0, in_ready;
  logic [ROB_AW-1:0] in_rob_addr = '0;
  logic              in_jump = 1'b0, in_predict_taken = 1'b0;
  logic [PC_W-1:0]   in_pc = '0, in_predict_target = '0;
  logic [D_AW-1:0]   in_rt_addr = '0, in_rw_addr = '0;
  logic [S_AW-1:0]   in_rs_addr = '0;
  logic [D_AW-1:0]   rt_rd_addr;
  logic [PC_W-1:0]   rt_rd_data;
  logic [S_AW-1:0]   rs_rd_addr;
  logic              rs_rd_data;
  logic              kill = 1'b0;
  logic              res_valid, res_mispredict, wb_valid, flush, redirect_valid;
  logic [ROB_AW-1:0] res_rob_addr, flush_rob_addr;
  logic [D_AW-1:0]   wb_addr;
  logic [PC_W-1:0]   wb_data, redirect_pc;

  branch_resolve_unit #(.PC_W(PC_W), .D_AW(D_AW), .S_AW(S_AW), .ROB_AW(ROB_AW), .RECOVER_CYC(RC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rob_addr(in_rob_addr),
    .in_jump(in_jump), .in_predict_taken(in_predict_taken), .in_pc(in_pc),
    .in_predict_target(in_predict_target), .in_rt_addr(in_rt_addr), .in_rw_addr(in_rw_addr),
    .in_rs_addr(in_rs_addr), .rt_rd_addr(rt_rd_addr), .rt_rd_data(rt_rd_data),
    .rs_rd_addr(rs_rd_addr), .rs_rd_data(rs_rd_data), .kill(kill), .res_valid(res_valid),
    .res_rob_addr(res_rob_addr), .res_mispredict(res_mispredict), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .flush_rob_addr(flush_rob_addr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc));

  always #5 clk = ~clk;

  // Register files seen by the unit's combinational read ports.
  logic [PC_W-1:0] drf [32];
  logic            srf [8];
  assign rt_rd_data = drf[rt_rd_addr];
  assign rs_rd_data = srf[rs_rd_addr];

  typedef struct {
    logic [3:0]  rob;
    logic        jump, pt, flag;
    logic [15:0] pc, ptgt, rt;
    logic [4:0]  rta, rwa;
    logic [2:0]  rsa;
  } stim_t;

  typedef struct {
    logic [3:0]  rob;
    logic        mis, jump;
    logic [4:0]  rw;
    logic [15:0] link, actual;
    int          due;
  } exp_t;

  exp_t q[$];
  int   tests = 0, fails = 0, cyc = 0;
  int   blk_lo = -1, blk_hi = -2;   // cycles in which no entry may be accepted
  int   last_acc = -10;
  bit   last_mis = 1'b0;            // last accepted entry will report a mispredict

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus: present inputs, check in_ready against the model, and
  // record the expected outcome of an accepted entry.
  task automatic drive(input bit v, input bit kl, input stim_t s);
    int k;
    bit er, taken, mis;
    logic [15:0] link, actual, pred_next;
    exp_t e;
    @(posedge clk); #1;
    k = cyc;
    drf[s.rta] = s.rt;
    srf[s.rsa] = s.flag;
    kill = kl; in_valid = v; in_rob_addr = s.rob; in_jump = s.jump;
    in_predict_taken = s.pt; in_pc = s.pc; in_predict_target = s.ptgt;
    in_rt_addr = s.rta; in_rw_addr = s.rwa; in_rs_addr = s.rsa;
    if (kl) begin
      // everything in flight (reporting now or next cycle) is discarded
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].due == k || q[i].due == k + 1) q.delete(i);
      if (blk_hi > k) blk_hi = k;
      last_mis = 1'b0;
    end
    er = !kl && !(k >= blk_lo && k <= blk_hi);
    #1;
    chk("in_ready", in_ready, er);
    if (v && er) begin
      taken     = s.jump || s.flag;
      link      = s.pc + 16'd1;
      actual    = taken ? s.rt : link;
      pred_next = s.pt ? s.ptgt : link;
      mis       = (taken != s.pt) || (taken && actual != pred_next);
      if (last_acc == k - 1 && last_mis) begin
        last_mis = 1'b0;  // younger than a mispredicting branch: squashed
      end else begin
        e.rob = s.rob; e.mis = mis; e.jump = s.jump; e.rw = s.rwa;
        e.link = link; e.actual = actual; e.due = k + 2;
        q.push_back(e);
        last_mis = mis;
        if (mis) begin
          blk_lo = k + 2;
          blk_hi = k + 2 + RC;
        end
      end
      last_acc = k;
    end
  endtask

  task automatic idle(input int n);
    stim_t z;
    z = '{rob: 4'h0, jump: 1'b0, pt: 1'b0, flag: srf[0], pc: 16'h0, ptgt: 16'h0,
          rt: drf[0], rta: 5'd0, rwa: 5'd0, rsa: 3'd0};
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, z);
  endtask

  // Monitor: compare every reported result against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      while (q.size() > 0 && q[0].due < cyc) begin
        tests++; fails++;
        $display("FAIL missing_result: rob %0h due cycle %0d, nothing reported by cycle %0d", q[0].rob, q[0].due, cyc);
        e = q.pop_front();
      end
      if (res_valid === 1'b1) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_result: rob %0h reported, none required (cycle %0d)", res_rob_addr, cyc);
        end else begin
          e = q.pop_front();
          chk("res_cycle", cyc, e.due);
          chk("res_rob_addr", res_rob_addr, e.rob);
          chk("res_mispredict", res_mispredict, e.mis);
          chk("wb_valid", wb_valid, e.jump);
          if (e.jump) begin
            chk("wb_addr", wb_addr, e.rw);
            chk("wb_data", wb_data, e.link);
          end
          chk("flush", flush, e.mis);
          chk("redirect_valid", redirect_valid, e.mis);
          if (e.mis) begin
            chk("redirect_pc", redirect_pc, e.actual);
            chk("flush_rob_addr", flush_rob_addr, e.rob);
          end
        end
      end else begin
        chk("quiet_outputs", {flush, redirect_valid, wb_valid}, 32'd0);
      end
    end
  end

  stim_t s;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 32; i++) drf[i] = 16'($urandom);
    for (int i = 0; i < 8; i++) srf[i] = 1'($urandom);
    repeat (2) @(posedge clk);
    #2;
    chk("reset_in_ready", in_ready, 32'd0);
    chk("reset_outputs", {res_valid, res_mispredict, wb_valid, flush, redirect_valid}, 32'd0);
    chk("reset_values", {res_rob_addr, flush_rob_addr, redirect_pc}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // correctly predicted taken branch
    s = '{rob: 4'h1, jump: 1'b0, pt: 1'b1, flag: 1'b1, pc: 16'h0010, ptgt: 16'h0040,
          rt: 16'h0040, rta: 5'd3, rwa: 5'd0, rsa: 3'd2};
    drive(1'b1, 1'b0, s); idle(3);
    // same branch not taken: redirect to pc+1, stall afterwards
    s.rob = 4'h2; s.flag = 1'b0;
    drive(1'b1, 1'b0, s); idle(5);
    // jump at the top of the address space: link wraps to 0
    s = '{rob: 4'h3, jump: 1'b1, pt: 1'b1, flag: 1'b0, pc: 16'hFFFF, ptgt: 16'h0020,
          rt: 16'h0020, rta: 5'd7, rwa: 5'd5, rsa: 3'd1};
    drive(1'b1, 1'b0, s); idle(3);
    // mispredicting branch followed immediately by a younger one
    s = '{rob: 4'h4, jump: 1'b0, pt: 1'b1, flag: 1'b0, pc: 16'h0100, ptgt: 16'h0200,
          rt: 16'h0200, rta: 5'd9, rwa: 5'd0, rsa: 3'd4};
    drive(1'b1, 1'b0, s);
    s.rob = 4'h5; s.pc = 16'h0101; s.flag = 1'b1; s.rta = 5'd10; s.rsa = 3'd5;
    drive(1'b1, 1'b0, s); idle(5);
    // kill coinciding with the mispredict resolving in E2
    s = '{rob: 4'h6, jump: 1'b0, pt: 1'b0, flag: 1'b1, pc: 16'h0300, ptgt: 16'h0000,
          rt: 16'h0400, rta: 5'd11, rwa: 5'd0, rsa: 3'd6};
    drive(1'b1, 1'b0, s); idle(1);
    drive(1'b0, 1'b1, s); idle(2);
    // reset during the recovery stall
    s.rob = 4'h7;
    drive(1'b1, 1'b0, s); idle(3);
    rst = 1'b1; #1;
    chk("rst_mid_stall_in_ready", in_ready, 32'd0);
    chk("rst_mid_stall_outputs", {res_valid, wb_valid, flush, redirect_valid, redirect_pc}, 32'd0);
    q.delete(); blk_lo = -1; blk_hi = -2; last_mis = 1'b0; last_acc = -10;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    s = '{rob: 4'h8, jump: 1'b0, pt: 1'b1, flag: 1'b1, pc: 16'h0500, ptgt: 16'h0600,
          rt: 16'h0600, rta: 5'd12, rwa: 5'd0, rsa: 3'd7};
    drive(1'b1, 1'b0, s); idle(3);

    // randomized traffic with occasional kills
    for (int i = 0; i < 1500; i++) begin
      s.rob  = 4'(i);
      s.jump = ($urandom % 4) == 0;
      s.flag = 1'($urandom);
      s.pc   = (($urandom % 16) == 0) ? 16'hFFFF : 16'($urandom);
      s.rt   = 16'($urandom);
      s.pt   = (($urandom % 4) != 0) ? (s.jump | s.flag) : 1'($urandom);
      s.ptgt = (($urandom % 4) != 0) ? s.rt : 16'($urandom);
      s.rta  = 5'($urandom);
      s.rwa  = 5'($urandom);
      s.rsa  = 3'($urandom);
      drive(($urandom % 4) != 0, ($urandom % 25) == 0, s);
    end
    idle(6);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
